// File: rtl/cpu_defs.sv
// Shared address-class constants and FSM encodings for the register-file write arbiter.
package cpu_defs;

    localparam logic [6:0] HI_ADDR    = 7'h7F;
    localparam logic [6:0] LO_ADDR    = 7'h40;
    localparam logic [6:0] ZERO_ADDR  = 7'h00;
    localparam logic [1:0] CP0_PREFIX = 2'b01;

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_e;

    typedef enum logic {
        AGE_NORMAL = 1'b0,
        AGE_FORCE  = 1'b1
    } age_state_e;

    // Any address with bit 6 set targets the HI/LO pair.
    function automatic logic is_hilo_addr(input logic [6:0] addr);
        return addr[6];
    endfunction

endpackage

// File: rtl/hl_result_buffer.sv
// One-entry mul/div result buffer with an aging counter that forces the result past WB HI/LO writes.
// Optional direct path to the HI/LO port when RF_ARB_HL_BYPASS_EN is defined.
import cpu_defs::*;

module hl_result_buffer #(
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        md_valid,
    input  logic [63:0] md_hilo,
    input  logic        wb_hl_grant,
    output logic        md_ready,
    output logic        pending,
    output logic        force_hl,
    output logic        grant,
    output logic        hl_we,
    output logic [63:0] hl_wdata
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

    buf_state_e       buf_state_r, buf_state_s;
    age_state_e       age_state_r, age_state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [63:0]      hold_r;
    logic             full_s, bypass_s, accept_s;

    assign full_s   = (buf_state_r == BUF_FULL);
    assign md_ready = (buf_state_r == BUF_EMPTY) & ~flush;
    assign force_hl = (age_state_r == AGE_FORCE);
    assign pending  = full_s;
    // A flush in the same cycle suppresses the write entirely.
    assign grant    = full_s & ~flush & (~wb_hl_grant | force_hl);

`ifdef RF_ARB_HL_BYPASS_EN
    assign bypass_s = md_ready & md_valid & ~wb_hl_grant;
`else
    assign bypass_s = 1'b0;
`endif

    assign accept_s = md_ready & md_valid & ~bypass_s;
    assign hl_we    = grant | bypass_s;
    assign hl_wdata = bypass_s ? md_hilo : hold_r;

    // Next-state logic for the buffer occupancy and aging FSMs.
    always_comb begin
        buf_state_s = buf_state_r;
        age_state_s = age_state_r;
        cnt_s       = cnt_r;
        case (buf_state_r)
            BUF_EMPTY: begin
                if (accept_s) begin
                    buf_state_s = BUF_FULL;
                end else begin
                    buf_state_s = BUF_EMPTY;
                end
            end
            BUF_FULL: begin
                if (grant || flush) begin
                    buf_state_s = BUF_EMPTY;
                end else begin
                    buf_state_s = BUF_FULL;
                end
            end
            default: buf_state_s = BUF_EMPTY;
        endcase
        if (!full_s || grant || flush) begin
            cnt_s       = {CNT_W{1'b0}};
            age_state_s = AGE_NORMAL;
        end else begin
            cnt_s       = (cnt_r == MAX_CNT) ? MAX_CNT : cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            age_state_s = (cnt_s == MAX_CNT) ? AGE_FORCE : AGE_NORMAL;
        end
    end

    // State, counter and hold register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_state_r <= BUF_EMPTY;
            age_state_r <= AGE_NORMAL;
            cnt_r       <= {CNT_W{1'b0}};
            hold_r      <= 64'h0;
        end else begin
            buf_state_r <= buf_state_s;
            age_state_r <= age_state_s;
            cnt_r       <= cnt_s;
            if (accept_s) begin
                hold_r <= md_hilo;
            end else begin
                hold_r <= hold_r;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register-file write port and HI/LO port among WB, exception and mul/div requesters.
// Optional feature macro: RF_ARB_HL_BYPASS_EN (mul/div result skips the buffer when the HI/LO port is idle).
import cpu_defs::*;

module regfile_wb_arbiter #(
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        wb_valid,
    output logic        wb_ready,
    input  logic [6:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [4:0]  ex_addr,
    input  logic [31:0] ex_data,
    input  logic        md_valid,
    output logic        md_ready,
    input  logic [63:0] md_hilo,
    output logic        regwrite,
    output logic [6:0]  write_addr,
    output logic [31:0] write_data,
    output logic        hl_write_enable,
    output logic [63:0] hl_data,
    output logic        hl_pending
);

    logic        force_s, grant_s, wb_hl_grant_s, hl_we_s;
    logic [63:0] hl_wdata_s;
    logic        regwrite_s;
    logic [6:0]  write_addr_s;
    logic [31:0] write_data_s;

    assign ex_ready      = ex_valid;
    assign wb_ready      = wb_valid & ~ex_valid & ~(force_s & is_hilo_addr(wb_addr));
    assign wb_hl_grant_s = wb_ready & is_hilo_addr(wb_addr);

    hl_result_buffer #(
        .MAX_WAIT (MAX_WAIT),
        .CNT_W    (CNT_W)
    ) u_buf (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .md_valid    (md_valid),
        .md_hilo     (md_hilo),
        .wb_hl_grant (wb_hl_grant_s),
        .md_ready    (md_ready),
        .pending     (hl_pending),
        .force_hl    (force_s),
        .grant       (grant_s),
        .hl_we       (hl_we_s),
        .hl_wdata    (hl_wdata_s)
    );

    // Select the write-port source; GPR 0 is accepted but never written.
    always_comb begin
        regwrite_s   = 1'b0;
        write_addr_s = write_addr;
        write_data_s = write_data;
        if (ex_valid) begin
            regwrite_s   = 1'b1;
            write_addr_s = {CP0_PREFIX, ex_addr};
            write_data_s = ex_data;
        end else if (wb_ready && (wb_addr != ZERO_ADDR)) begin
            regwrite_s   = 1'b1;
            write_addr_s = wb_addr;
            write_data_s = wb_data;
        end else begin
            regwrite_s   = 1'b0;
        end
    end

    // Registered outputs towards the register file.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regwrite        <= 1'b0;
            write_addr      <= 7'h00;
            write_data      <= 32'h0;
            hl_write_enable <= 1'b0;
            hl_data         <= 64'h0;
        end else begin
            regwrite        <= regwrite_s;
            write_addr      <= write_addr_s;
            write_data      <= write_data_s;
            hl_write_enable <= hl_we_s;
            if (hl_we_s) begin
                hl_data <= hl_wdata_s;
            end else begin
                hl_data <= hl_data;
            end
        end
    end

    // grant_s is consumed inside the buffer; kept visible here for debug probing.
    logic unused_s;
    assign unused_s = grant_s;

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's write port and its HI/LO write port among three requesters:
  - the pipeline WB stage (GPR/HI/LO/CP0 writes);
  - the multi-cycle mul/div unit (64-bit HI/LO result);
  - the exception unit (CP0 writes).
- Sits between WB/mul-div/exception logic and the register file. Drives its regwrite, write_addr, write_data, hl_write_enable_from_wb and hl_data inputs from registered outputs.
- Buffers one mul/div result. Ages it so that HI/LO writes from WB cannot starve it.

Parameters:
- MAX_WAIT, 4: cycles a buffered mul/div result may lose arbitration before it is forced through (1..15).
- CNT_W, 4: width of the aging counter; must satisfy 2^CNT_W > MAX_WAIT.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- flush  in  1  exception flush; discards the pending mul/div result.
- wb_valid  in  1  WB write request.
- wb_ready  out  1  WB request granted this cycle (combinational).
- wb_addr  in  7  7-bit register-file address. [6]=1 selects HI/LO (7'h7F=HI, 7'h40=LO); [5]=1 selects CP0; otherwise GPR [4:0].
- wb_data  in  32  WB write data.
- ex_valid  in  1  exception-unit CP0 write request.
- ex_ready  out  1  exception-unit request granted (combinational).
- ex_addr  in  5  CP0 register number.
- ex_data  in  32  CP0 write data.
- md_valid  in  1  mul/div result valid.
- md_ready  out  1  result buffer can accept (combinational).
- md_hilo  in  64  {HI,LO} result.
- regwrite  out  1  register-file write enable (registered).
- write_addr  out  7  register-file write address (registered).
- write_data  out  32  register-file write data (registered).
- hl_write_enable  out  1  HI/LO dual write enable (registered).
- hl_data  out  64  {HI,LO} write data (registered).
- hl_pending  out  1  buffer holds an unwritten HI/LO result; ID stalls MFHI/MFLO on it.

Behaviour:
- Transfers occur on valid & ready. A transfer at cycle T appears on the registered outputs at T+1 and lasts exactly one cycle.
- Reset (rst=0, asynchronous):
  - regwrite=0, write_addr=7'h00, write_data=0;
  - hl_write_enable=0, hl_data=0;
  - buffer EMPTY, state NORMAL, counter=0, hl_pending=0.
- Write-port arbitration:
  - ex has priority over wb. ex_ready=ex_valid.
  - wb_ready=wb_valid & ~ex_valid & ~(state==FORCE & wb_addr[6]).
  - An ex grant drives write_addr={2'b01,ex_addr}.
  - A wb grant with wb_addr==7'h00 is accepted (wb_ready=1) but drives regwrite=0. GPR 0 is never written.
- HI/LO arbitration: the buffered result (hold register) is granted when buffer FULL and
  - no wb HI/LO grant this cycle, or
  - state==FORCE.
  - A GPR/CP0 write and a HI/LO write may issue in the same cycle.
- Buffer FSM (EMPTY/FULL):
  - md_ready = EMPTY & ~flush.
  - EMPTY to FULL on md transfer.
  - FULL to EMPTY on HI/LO grant or flush.
  - hl_pending = FULL.
- Aging FSM (NORMAL/FORCE):
  - Counter increments each cycle the buffer is FULL and not granted.
  - When the counter reaches MAX_WAIT, go to FORCE.
  - On grant or flush: counter=0, state=NORMAL.
  - Counter saturates at MAX_WAIT.
- Flush:
  - Buffer cleared with no write. A grant in the same cycle is suppressed.
  - ex/wb paths are unaffected.
  - An md_valid asserted during flush is not accepted.
- Reset mid-operation: buffered result lost; no write issued.
- Latency without bypass: md accepted at T, FULL at T+1, hl_write_enable at T+2 at the earliest.

Optional Feature:
- Macro RF_ARB_HL_BYPASS_EN.
- When defined: if buffer EMPTY, md_valid=1, no flush, and no wb HI/LO grant this cycle, the result goes directly to hl_data/hl_write_enable at T+1. The buffer stays EMPTY and hl_pending stays 0.
- When undefined: every result passes through the buffer (minimum latency 2).

Decomposition:
- Shared package (cpu_defs):
  - address-class constants: HI_ADDR=7'h7F, LO_ADDR=7'h40, CP0 prefix 2'b01;
  - buffer state encoding (EMPTY/FULL) and aging state encoding (NORMAL/FORCE).
- One natural sub-module: hl_result_buffer. It holds the buffer, the aging counter and both FSMs, and exposes pending/force/grant.

Test Plan:
- wb_valid=1, wb_addr=7'h05, wb_data=32'hDEAD_BEEF at T -> T+1: regwrite=1, write_addr=7'h05, write_data=32'hDEAD_BEEF; T+2: regwrite=0.
- ex_valid=1 (ex_addr=5'd14, data 32'hBFC0_0380) and wb_valid=1 in the same cycle -> ex_ready=1, wb_ready=0; write_addr=7'h2E next cycle; wb granted the following cycle.
- md_hilo=64'h1_0000_0002 accepted while wb writes 7'h7F for 5 consecutive cycles, MAX_WAIT=4 -> hl_pending=1 throughout; after 4 losses wb_ready drops; hl_write_enable=1 with hl_data=64'h1_0000_0002; counter clears.
- Buffer FULL, flush=1 with md_valid=1 -> no hl_write_enable ever; md_ready=0 that cycle; hl_pending=0 next cycle.
- wb_valid=1, wb_addr=7'h00 -> wb_ready=1, regwrite stays 0.
- With RF_ARB_HL_BYPASS_EN, md_valid at T on an idle bus -> hl_write_enable=1 at T+1 and hl_pending never asserted; without the macro -> hl_write_enable at T+2.
